board_redraw_engine: RTL and testbench
======================================

Name: board_redraw_engine

Overview:
- Parametrised board redraw sequencer for the othello VGA path.
- Walks an N x N board snapshot in row-major order and emits one plot request per cell: empty, black or white.
- Two modes: full (every cell) or partial (only cells whose dirty bit is set). An optional cursor-frame request follows the board walk.
- Sits between the board RAM / control FSM and the plot helper. Every request uses a valid/ready handshake, so the plotter can stall it.

Parameters:
- BOARD_N, 8, cells per side.
- CELL_PX, 12, cell pitch in pixels.
- X0, 16, screen x of cell (0,0).
- Y0, 12, screen y of cell (0,0).
- CW, $clog2(BOARD_N), width of a cell coordinate.
- IDX_W, $clog2(BOARD_N*BOARD_N), width of a cell index.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- full_mode  in  1  1 = draw all cells, 0 = draw dirty cells only
- show_cursor  in  1  append a cursor-frame request
- board  in  2*BOARD_N*BOARD_N  cell i at [2i+1:2i]; i = y*BOARD_N + x
- dirty  in  BOARD_N*BOARD_N  per-cell redraw flags
- cursor_x, cursor_y  in  CW  cursor cell
- req_valid  out  1  plot request valid
- req_ready  in  1  plotter accepts
- req_x  out  8  pixel x
- req_y  out  7  pixel y
- req_select  out  2  0 empty, 1 black, 2 white, 3 cursor
- busy  out  1  high from LOAD until DONE inclusive
- done  out  1  one-cycle pulse at frame end
- cells_drawn  out  IDX_W+1  handshakes completed in the current or last frame

Behaviour:
- Reset: state IDLE. req_valid, busy, done, cells_drawn, req_x, req_y and req_select are all 0.
- Reset mid-frame: all of the above take reset values at the same edge; no done pulse is produced.
- States: IDLE, LOAD, SCAN, ISSUE, CURSOR, DONE.
- IDLE -> LOAD when start=1.
- start while not in IDLE is ignored; it is not queued.
- LOAD, 1 cycle:
  - Snapshot board, dirty, full_mode, show_cursor, cursor_x and cursor_y.
  - Cell index = 0; cells_drawn = 0.
  - Inputs that change after this cycle do not affect the frame.
- SCAN, 1 cycle per cell:
  - A cell is drawn if full_mode is set or its dirty bit is set.
  - Drawn cell: load req_x/req_y/req_select, set req_valid, go to ISSUE.
  - Skipped cell: advance the index and stay in SCAN.
  - After index N*N-1: go to CURSOR if show_cursor, else DONE.
- ISSUE:
  - Hold req_valid and keep req_x/req_y/req_select stable until the edge where req_valid & req_ready.
  - At that edge: clear req_valid, increment cells_drawn, then advance to the next cell (SCAN), or to CURSOR/DONE after the last cell.
  - req_ready already high before valid is legal; the handshake completes on the first ISSUE cycle.
- CURSOR:
  - Issue one request at the cursor cell with select 3, same handshake rules.
  - It increments cells_drawn, then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- Select mapping: board code 0 -> 0, 1 -> 1, 2 -> 2, 3 (illegal) -> 0.
- Pixel address:
  - req_x = X0 + x*CELL_PX, req_y = Y0 + y*CELL_PX.
  - Produced by incremental add counters, with no multiplier: +CELL_PX per column; wrap to X0 and add CELL_PX to y at row end.
  - The cursor address is computed by stepping during LOAD/SCAN or by a small constant multiply; either is acceptable.
- Elaboration check: X0 + BOARD_N*CELL_PX <= 160 and Y0 + BOARD_N*CELL_PX <= 120, else $error.
- Latency with req_ready tied 1: done rises 1 + 2*D + S + 2*C edges after the start-sampling edge.
  - D = drawn cells, S = skipped cells, C = cursor requests (0 or 1).
- Partial mode with an all-zero mask and cursor off: zero requests; done after 1 + N*N edges.

Decomposition:
- Package othello_pkg holds:
  - Cell codes CELL_EMPTY/CELL_BLACK/CELL_WHITE.
  - Select codes SEL_EMPTY/SEL_BLACK/SEL_WHITE/SEL_CURSOR.
  - SCREEN_W=160, SCREEN_H=120.
  - The FSM state enum.
- Sub-module cell_pixel_stepper owns the cell index and x/y pixel counters:
  - clear, step, and a last flag.
  - It is reused by future animation blocks.

Test Plan:
- Reset held 3 cycles, then released: all outputs 0, state IDLE; start during reset is ignored.
- Full mode, all-empty board, ready=1: 64 requests, all select 0.
  - Request 1 = (16,12), request 2 = (28,12), request 9 = (16,24), request 64 = (100,96).
  - done 129 edges after start; cells_drawn=64.
- Partial mode, dirty bits 27, 28, 35, 36 set, board 27=2, 28=1, 35=1, 36=2: exactly 4 requests.
  - Requests: (52,48,2), (64,48,1), (52,60,1), (64,60,2).
  - done at edge 69; cells_drawn=4.
- Backpressure: ready low for 5 cycles while request 2 is valid.
  - req_valid stays 1 and x/y/select stay stable; cells_drawn is unchanged until ready returns.
  - A start pulse mid-frame has no effect.
- Cursor: partial mode, mask 0, show_cursor=1, cursor (7,7): single request (100,96,3); done at edge 67.
  - Board cell coded 3 in full mode -> select 0.
- Reset asserted during ISSUE of cell 10: next cycle req_valid=0, busy=0, done never pulses.
  - A new start then redraws from (16,12).

Source files
------------

// File: rtl/othello_pkg.sv
// Shared codes and screen geometry for the othello VGA drawing path.
package othello_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_BLACK = 2'd1;
    localparam logic [1:0] CELL_WHITE = 2'd2;

    localparam logic [1:0] SEL_EMPTY  = 2'd0;
    localparam logic [1:0] SEL_BLACK  = 2'd1;
    localparam logic [1:0] SEL_WHITE  = 2'd2;
    localparam logic [1:0] SEL_CURSOR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SCAN   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_CURSOR = 3'd4,
        ST_DONE   = 3'd5
    } redraw_state_e;

    // Illegal cell code 3 is drawn as an empty cell.
    function automatic logic [1:0] cell_to_sel(input logic [1:0] code);
        logic [1:0] sel;
        case (code)
            CELL_BLACK: sel = SEL_BLACK;
            CELL_WHITE: sel = SEL_WHITE;
            default:    sel = SEL_EMPTY;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/cell_pixel_stepper.sv
// Row-major cell index walker with incremental pixel x/y counters (no multiplier).
module cell_pixel_stepper #(
    parameter int unsigned BOARD_N = 8,
    parameter int unsigned CELL_PX = 12,
    parameter int unsigned X0      = 16,
    parameter int unsigned Y0      = 12,
    parameter int unsigned IDX_W   = $clog2(BOARD_N * BOARD_N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    output logic [IDX_W-1:0] idx,
    output logic [7:0]       px_x,
    output logic [6:0]       px_y,
    output logic             last_c
);

    localparam int unsigned COL_W = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;

    logic [COL_W-1:0] col;

    assign last_c = (idx == IDX_W'(BOARD_N * BOARD_N - 1));

    // Column wrap resets x to the left edge and moves y down one cell.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            idx  <= '0;
            col  <= '0;
            px_x <= 8'(X0);
            px_y <= 7'(Y0);
        end else if (step) begin
            idx <= idx + IDX_W'(1);
            if (col == COL_W'(BOARD_N - 1)) begin
                col  <= '0;
                px_x <= 8'(X0);
                px_y <= px_y + 7'(CELL_PX);
            end else begin
                col  <= col + COL_W'(1);
                px_x <= px_x + 8'(CELL_PX);
            end
        end
    end

endmodule

// File: rtl/board_redraw_engine.sv
// Walks a board snapshot and issues one plot request per drawn cell, plus an optional cursor frame.
module board_redraw_engine
    import othello_pkg::*;
#(
    parameter int unsigned BOARD_N = 8,
    parameter int unsigned CELL_PX = 12,
    parameter int unsigned X0      = 16,
    parameter int unsigned Y0      = 12,
    parameter int unsigned CW      = $clog2(BOARD_N),
    parameter int unsigned IDX_W   = $clog2(BOARD_N * BOARD_N)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         full_mode,
    input  logic                         show_cursor,
    input  logic [2*BOARD_N*BOARD_N-1:0] board,
    input  logic [BOARD_N*BOARD_N-1:0]   dirty,
    input  logic [CW-1:0]                cursor_x,
    input  logic [CW-1:0]                cursor_y,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [7:0]                   req_x,
    output logic [6:0]                   req_y,
    output logic [1:0]                   req_select,
    output logic                         busy,
    output logic                         done,
    output logic [IDX_W:0]               cells_drawn
);

    if ((X0 + BOARD_N * CELL_PX > SCREEN_W) || (Y0 + BOARD_N * CELL_PX > SCREEN_H)) begin : g_geometry_check
        $error("board_redraw_engine: board geometry exceeds the screen");
    end

    redraw_state_e state_q, state_d;

    logic [2*BOARD_N*BOARD_N-1:0] board_q;
    logic [BOARD_N*BOARD_N-1:0]   dirty_q;
    logic                         full_q;
    logic                         show_q;
    logic [7:0]                   cur_px_x;
    logic [6:0]                   cur_px_y;
    logic                         is_cursor_q, is_cursor_d;

    logic                         req_valid_d;
    logic [7:0]                   req_x_d;
    logic [6:0]                   req_y_d;
    logic [1:0]                   req_select_d;
    logic                         busy_d;
    logic                         done_d;
    logic [IDX_W:0]               cells_drawn_d;

    logic                         st_clear;
    logic                         st_step;
    logic [IDX_W-1:0]             st_idx;
    logic [7:0]                   st_px_x;
    logic [6:0]                   st_px_y;
    logic                         st_last_c;
    logic                         cell_drawn_c;
    logic [1:0]                   cell_code_c;

    cell_pixel_stepper #(
        .BOARD_N (BOARD_N),
        .CELL_PX (CELL_PX),
        .X0      (X0),
        .Y0      (Y0),
        .IDX_W   (IDX_W)
    ) u_stepper (
        .clock  (clock),
        .reset  (reset),
        .clear  (st_clear),
        .step   (st_step),
        .idx    (st_idx),
        .px_x   (st_px_x),
        .px_y   (st_px_y),
        .last_c (st_last_c)
    );

    assign cell_drawn_c = full_q | dirty_q[st_idx];
    assign cell_code_c  = board_q[{st_idx, 1'b0} +: 2];

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d       = state_q;
        st_clear      = 1'b0;
        st_step       = 1'b0;
        is_cursor_d   = is_cursor_q;
        req_valid_d   = req_valid;
        req_x_d       = req_x;
        req_y_d       = req_y;
        req_select_d  = req_select;
        cells_drawn_d = cells_drawn;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                st_clear      = 1'b1;
                is_cursor_d   = 1'b0;
                cells_drawn_d = '0;
                state_d       = ST_SCAN;
            end
            ST_SCAN: begin
                if (cell_drawn_c) begin
                    req_valid_d  = 1'b1;
                    req_x_d      = st_px_x;
                    req_y_d      = st_px_y;
                    req_select_d = cell_to_sel(cell_code_c);
                    state_d      = ST_ISSUE;
                end else if (st_last_c) begin
                    state_d = show_q ? ST_CURSOR : ST_DONE;
                end else begin
                    st_step = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (req_ready) begin
                    req_valid_d   = 1'b0;
                    cells_drawn_d = cells_drawn + (IDX_W + 1)'(1);
                    if (is_cursor_q) begin
                        state_d = ST_DONE;
                    end else if (st_last_c) begin
                        state_d = show_q ? ST_CURSOR : ST_DONE;
                    end else begin
                        st_step = 1'b1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_CURSOR: begin
                req_valid_d  = 1'b1;
                req_x_d      = cur_px_x;
                req_y_d      = cur_px_y;
                req_select_d = SEL_CURSOR;
                is_cursor_d  = 1'b1;
                state_d      = ST_ISSUE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            is_cursor_q <= 1'b0;
            req_valid   <= 1'b0;
            req_x       <= '0;
            req_y       <= '0;
            req_select  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cells_drawn <= '0;
        end else begin
            state_q     <= state_d;
            is_cursor_q <= is_cursor_d;
            req_valid   <= req_valid_d;
            req_x       <= req_x_d;
            req_y       <= req_y_d;
            req_select  <= req_select_d;
            busy        <= busy_d;
            done        <= done_d;
            cells_drawn <= cells_drawn_d;
        end
    end

    // Frame snapshot; later input changes cannot disturb a frame in flight.
    always_ff @(posedge clock) begin
        if (state_q == ST_LOAD) begin
            board_q  <= board;
            dirty_q  <= dirty;
            full_q   <= full_mode;
            show_q   <= show_cursor;
            cur_px_x <= 8'(X0) + 8'(cursor_x) * 8'(CELL_PX);
            cur_px_y <= 7'(Y0) + 7'(cursor_y) * 7'(CELL_PX);
        end
    end

endmodule

// File: tb/tb_board_redraw_engine.sv
// Self-checking bench for board_redraw_engine: vector table, hand sequences and randomized frames.
module tb_board_redraw_engine;

    localparam int N  = 8;
    localparam int NN = N * N;
    localparam int PX = 12;
    localparam int XO = 16;
    localparam int YO = 12;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic            full_mode;
    logic            show_cursor;
    logic [2*NN-1:0] board;
    logic [NN-1:0]   dirty;
    logic [2:0]      cursor_x;
    logic [2:0]      cursor_y;
    logic            req_valid;
    logic            req_ready;
    logic [7:0]      req_x;
    logic [6:0]      req_y;
    logic [1:0]      req_select;
    logic            busy;
    logic            done;
    logic [6:0]      cells_drawn;

    board_redraw_engine dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .full_mode   (full_mode),
        .show_cursor (show_cursor),
        .board       (board),
        .dirty       (dirty),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_select  (req_select),
        .busy        (busy),
        .done        (done),
        .cells_drawn (cells_drawn)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int s;
    } req_t;

    typedef struct {
        logic            fm;
        logic            sc;
        logic [2*NN-1:0] brd;
        logic [NN-1:0]   drt;
        logic [2:0]      cx;
        logic [2:0]      cy;
        int              exp_n;
        int              f_x, f_y, f_s;
        int              l_x, l_y, l_s;
        int              p_i, p_x, p_y, p_s;
        int              exp_done;
    } vec_t;

    req_t got[$];
    req_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic logic [2*NN-1:0] put_cell(input logic [2*NN-1:0] b, input int i, input logic [1:0] code);
        logic [2*NN-1:0] r;
        r = b;
        r[2*i +: 2] = code;
        return r;
    endfunction

    // Reference: list of requests and latency from the frame rules, not the RTL structure.
    task automatic build_model(input logic fm, input logic sc, input logic [2*NN-1:0] brd,
                               input logic [NN-1:0] drt, input logic [2:0] cx, input logic [2:0] cy,
                               output int lat);
        int d;
        int s;
        req_t r;
        exp_q.delete();
        d = 0;
        s = 0;
        for (int i = 0; i < NN; i++) begin
            if (fm || drt[i]) begin
                r.x = XO + (i % N) * PX;
                r.y = YO + (i / N) * PX;
                r.s = (brd[2*i +: 2] == 2'd3) ? 0 : int'(brd[2*i +: 2]);
                exp_q.push_back(r);
                d++;
            end else begin
                s++;
            end
        end
        if (sc) begin
            r.x = XO + int'(cx) * PX;
            r.y = YO + int'(cy) * PX;
            r.s = 3;
            exp_q.push_back(r);
        end
        lat = 1 + 2 * d + s + (sc ? 2 : 0);
    endtask

    // rmode 0: ready always 1; 1: random ready and input noise; 2: stall request stall_k for 5 cycles.
    task automatic run_frame(input logic fm, input logic sc, input logic [2*NN-1:0] brd,
                             input logic [NN-1:0] drt, input logic [2:0] cx, input logic [2:0] cy,
                             input int rmode, input int stall_k, output int done_edge, output int stalls);
        int   edge_n;
        int   hold;
        logic prev_stall;
        req_t pv;
        int   pv_cells;
        req_t r;
        got.delete();
        stalls     = 0;
        done_edge  = -1;
        hold       = 0;
        prev_stall = 1'b0;
        pv_cells   = 0;
        pv         = '{0, 0, 0};
        @(negedge clock);
        full_mode   = fm;
        show_cursor = sc;
        board       = brd;
        dirty       = drt;
        cursor_x    = cx;
        cursor_y    = cy;
        req_ready   = 1'b1;
        start       = 1'b1;
        @(posedge clock);
        edge_n = 0;
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clock);
            if (edge_n >= 1 && rmode != 0) begin
                board       = {$urandom, $urandom, $urandom, $urandom};
                dirty       = {$urandom, $urandom};
                full_mode   = 1'($urandom);
                show_cursor = 1'($urandom);
                cursor_x    = 3'($urandom);
                cursor_y    = 3'($urandom);
                start       = ($urandom % 4 == 0);
            end
            case (rmode)
                1: req_ready = ($urandom % 3 != 0);
                2: begin
                    if (got.size() == stall_k && req_valid && hold < 5) begin
                        req_ready = 1'b0;
                        hold++;
                    end else begin
                        req_ready = 1'b1;
                    end
                end
                default: req_ready = 1'b1;
            endcase
            if (prev_stall) begin
                chk("stall_valid", int'(req_valid), 1);
                chk("stall_x", int'(req_x), pv.x);
                chk("stall_y", int'(req_y), pv.y);
                chk("stall_sel", int'(req_select), pv.s);
                chk("stall_cells", int'(cells_drawn), pv_cells);
            end
            prev_stall = 1'b0;
            if (req_valid && req_ready) begin
                r.x = int'(req_x);
                r.y = int'(req_y);
                r.s = int'(req_select);
                got.push_back(r);
            end else if (req_valid) begin
                stalls++;
                prev_stall = 1'b1;
                pv.x     = int'(req_x);
                pv.y     = int'(req_y);
                pv.s     = int'(req_select);
                pv_cells = int'(cells_drawn);
            end
            @(posedge clock);
            edge_n++;
            #1;
            if (done) begin
                done_edge = edge_n;
                break;
            end
        end
        start     = 1'b0;
        req_ready = 1'b1;
        if (done_edge < 0) begin
            n_checks++;
            $display("FAIL frame_timeout: got no done expected done within 1000 cycles");
        end
    endtask

    // Compare a finished frame against the model, then confirm the frame closes cleanly.
    task automatic check_frame(input string tag, input logic fm, input logic sc, input logic [2*NN-1:0] brd,
                               input logic [NN-1:0] drt, input logic [2:0] cx, input logic [2:0] cy,
                               input int done_edge, input int stalls);
        int lat;
        build_model(fm, sc, brd, drt, cx, cy, lat);
        chk({tag, "_req_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            if (got[i] != exp_q[i]) begin
                n_checks++;
                $display("FAIL %s_req%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", tag, i,
                         got[i].x, got[i].y, got[i].s, exp_q[i].x, exp_q[i].y, exp_q[i].s);
            end else begin
                n_checks++;
                n_pass++;
            end
        end
        chk({tag, "_done_edge"}, done_edge, lat + stalls);
        chk({tag, "_cells_drawn"}, int'(cells_drawn), exp_q.size());
        chk({tag, "_busy_at_done"}, int'(busy), 1);
        @(posedge clock);
        #1;
        chk({tag, "_done_pulse_end"}, int'(done), 0);
        chk({tag, "_busy_end"}, int'(busy), 0);
        repeat (3) @(posedge clock);
        #1 chk({tag, "_start_not_queued"}, int'(busy), 0);
    endtask

    vec_t            vecs[7];
    logic [2*NN-1:0] b4;
    logic [NN-1:0]   d4;
    int              de;
    int              st;
    int              guard;

    initial begin
        reset       = 1'b1;
        start       = 1'b1;
        full_mode   = 1'b1;
        show_cursor = 1'b0;
        board       = '0;
        dirty       = '0;
        cursor_x    = '0;
        cursor_y    = '0;
        req_ready   = 1'b1;

        // Reset held 3 cycles with start asserted.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", int'(req_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cells", int'(cells_drawn), 0);
        chk("rst_x", int'(req_x), 0);
        chk("rst_y", int'(req_y), 0);
        chk("rst_sel", int'(req_select), 0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk("rst_release_idle", int'(busy), 0);

        // Directed vector table.
        b4 = '0;
        b4 = put_cell(b4, 27, 2'd2);
        b4 = put_cell(b4, 28, 2'd1);
        b4 = put_cell(b4, 35, 2'd1);
        b4 = put_cell(b4, 36, 2'd2);
        d4 = '0;
        d4[27] = 1'b1;
        d4[28] = 1'b1;
        d4[35] = 1'b1;
        d4[36] = 1'b1;
        vecs[0] = '{1'b1, 1'b0, '0, '0, 3'd0, 3'd0, 64, 16, 12, 0, 100, 96, 0, 1, 28, 12, 0, 129};
        vecs[1] = '{1'b1, 1'b0, '0, '0, 3'd0, 3'd0, 64, 16, 12, 0, 100, 96, 0, 8, 16, 24, 0, 129};
        vecs[2] = '{1'b0, 1'b0, b4, d4, 3'd0, 3'd0, 4, 52, 48, 2, 64, 60, 2, 1, 64, 48, 1, 69};
        vecs[3] = '{1'b0, 1'b1, '0, '0, 3'd7, 3'd7, 1, 100, 96, 3, 100, 96, 3, 0, 100, 96, 3, 67};
        vecs[4] = '{1'b0, 1'b0, b4, '0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 65};
        vecs[5] = '{1'b1, 1'b1, {(2*NN){1'b1}}, '0, 3'd0, 3'd0, 65, 16, 12, 0, 16, 12, 3, 63, 100, 96, 0, 131};
        vecs[6] = '{1'b1, 1'b0, 128'h1, '0, 3'd0, 3'd0, 64, 16, 12, 1, 100, 96, 0, 1, 28, 12, 0, 129};
        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].fm, vecs[v].sc, vecs[v].brd, vecs[v].drt, vecs[v].cx, vecs[v].cy, 0, 0, de, st);
            chk($sformatf("vec%0d_count", v), got.size(), vecs[v].exp_n);
            chk($sformatf("vec%0d_done", v), de, vecs[v].exp_done);
            if (vecs[v].exp_n > 0 && got.size() > 0 && got.size() > vecs[v].p_i) begin
                chk($sformatf("vec%0d_first_x", v), got[0].x, vecs[v].f_x);
                chk($sformatf("vec%0d_first_y", v), got[0].y, vecs[v].f_y);
                chk($sformatf("vec%0d_first_s", v), got[0].s, vecs[v].f_s);
                chk($sformatf("vec%0d_last_x", v), got[got.size()-1].x, vecs[v].l_x);
                chk($sformatf("vec%0d_last_y", v), got[got.size()-1].y, vecs[v].l_y);
                chk($sformatf("vec%0d_last_s", v), got[got.size()-1].s, vecs[v].l_s);
                chk($sformatf("vec%0d_probe_x", v), got[vecs[v].p_i].x, vecs[v].p_x);
                chk($sformatf("vec%0d_probe_y", v), got[vecs[v].p_i].y, vecs[v].p_y);
                chk($sformatf("vec%0d_probe_s", v), got[vecs[v].p_i].s, vecs[v].p_s);
            end
            check_frame($sformatf("vec%0d", v), vecs[v].fm, vecs[v].sc, vecs[v].brd, vecs[v].drt,
                        vecs[v].cx, vecs[v].cy, de, st);
        end

        // Backpressure on request 2 for 5 cycles, with noisy inputs and start pulses mid-frame.
        run_frame(1'b0, 1'b0, b4, d4, 3'd0, 3'd0, 2, 1, de, st);
        chk("bp_stalls", st, 5);
        chk("bp_done", de, 74);
        check_frame("bp", 1'b0, 1'b0, b4, d4, 3'd0, 3'd0, de, st);

        // Reset while cell 10 is waiting in ISSUE.
        @(negedge clock);
        full_mode   = 1'b1;
        show_cursor = 1'b0;
        board       = '0;
        dirty       = '0;
        req_ready   = 1'b1;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
        guard = 0;
        while (!(req_valid && cells_drawn == 7'd10) && guard < 200) begin
            req_ready = (cells_drawn != 7'd10);
            @(negedge clock);
            guard++;
        end
        req_ready = 1'b0;
        chk("rst_mid_reached", int'(guard < 200), 1);
        chk("rst_mid_cell10_x", int'(req_x), 40);
        chk("rst_mid_cell10_y", int'(req_y), 24);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_mid_valid", int'(req_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_cells", int'(cells_drawn), 0);
        @(negedge clock);
        reset     = 1'b0;
        req_ready = 1'b1;
        guard     = 0;
        repeat (5) begin
            @(posedge clock);
            #1 if (done) guard++;
        end
        chk("rst_mid_no_done", guard, 0);
        run_frame(1'b1, 1'b0, '0, '0, 3'd0, 3'd0, 0, 0, de, st);
        if (got.size() > 0) begin
            chk("rst_mid_redraw_x", got[0].x, 16);
            chk("rst_mid_redraw_y", got[0].y, 12);
        end
        check_frame("redraw", 1'b1, 1'b0, '0, '0, 3'd0, 3'd0, de, st);

        // Randomized frames against the reference model.
        for (int k = 0; k < 16; k++) begin
            logic            rfm;
            logic            rsc;
            logic [2*NN-1:0] rb;
            logic [NN-1:0]   rd;
            logic [2:0]      rcx;
            logic [2:0]      rcy;
            rfm = ($urandom % 3 == 0);
            rsc = 1'($urandom);
            rb  = {$urandom, $urandom, $urandom, $urandom};
            rd  = {$urandom, $urandom} & {$urandom, $urandom};
            rcx = 3'($urandom);
            rcy = 3'($urandom);
            run_frame(rfm, rsc, rb, rd, rcx, rcy, 1, 0, de, st);
            check_frame($sformatf("rand%0d", k), rfm, rsc, rb, rd, rcx, rcy, de, st);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
